// File: rtl/intercore_lock_arbiter_pkg.sv
// Shared constants for the inter-core spinlock unit: sreg addresses and STAT word layout.
package intercore_lock_arbiter_pkg;

  localparam int RW_CFG = 16;

  localparam logic [RW_CFG-1:0] SREG_LOCK_ACQ  = 16'h000C;
  localparam logic [RW_CFG-1:0] SREG_LOCK_REL  = 16'h000D;
  localparam logic [RW_CFG-1:0] SREG_LOCK_STAT = 16'h000E;

  localparam int STAT_ERR_BIT  = 14;
  localparam int STAT_PEND_BIT = 15;

endpackage

// File: rtl/intercore_lock_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (wrapping) wins.
module rr_arbiter
  import intercore_lock_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end

endmodule

// File: rtl/intercore_lock_arbiter.sv
// Hardware spinlock unit on the per-core sreg bus: round-robin acquire, pending waiters,
// same-edge hand-off on release and force-release of disabled cores.
module intercore_lock_arbiter
  import intercore_lock_arbiter_pkg::*;
#(
  parameter int CORES = 2,
  parameter int LOCKS = 8,
  parameter int RW    = RW_CFG
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CORES*RW-1:0] i_sr_addr,
  input  logic [CORES*RW-1:0] i_sr_data,
  input  logic [CORES-1:0]    i_sr_we,
  output logic [CORES*RW-1:0] o_sr_data,
  input  logic [CORES-1:0]    i_core_disable,
  output logic [CORES-1:0]    o_grant_irq
);

  localparam int IDW = (LOCKS > 1) ? $clog2(LOCKS) : 1;
  localparam int CPW = (CORES > 1) ? $clog2(CORES) : 1;

  logic [LOCKS-1:0] owner_v, owner_v_s, owner_v_n;
  logic [CPW-1:0]   owner_id   [LOCKS];
  logic [CPW-1:0]   owner_id_n [LOCKS];
  logic [CORES-1:0] pend_v, pend_eff, pend_v_n;
  logic [IDW-1:0]   pend_id   [CORES];
  logic [IDW-1:0]   pend_id_n [CORES];
  logic [CPW-1:0]   rr_ptr, rr_ptr_n;
  logic [CORES-1:0] err, err_n, grant_irq, grant_irq_n;

  logic [RW-1:0]    addr [CORES];
  logic [RW-1:0]    data [CORES];
  logic [IDW-1:0]   wid  [CORES];
  logic [CORES-1:0] is_acq, is_rel, bad_id, stat_clr, acq_v, won;

  logic [CORES-1:0] req     [LOCKS];
  logic [CORES-1:0] gnt     [LOCKS];
  logic [CPW-1:0]   gnt_idx [LOCKS];
  logic [LOCKS-1:0] gnt_any;
  logic             rr_done;

  // Per-core write decode; a disabled core's acquire/release writes are dropped.
  always_comb begin
    addr     = '{default: '0};
    data     = '{default: '0};
    wid      = '{default: '0};
    is_acq   = '0;
    is_rel   = '0;
    bad_id   = '0;
    stat_clr = '0;
    for (int c = 0; c < CORES; c++) begin
      addr[c]     = i_sr_addr[c*RW +: RW];
      data[c]     = i_sr_data[c*RW +: RW];
      wid[c]      = data[c][IDW-1:0];
      is_acq[c]   = i_sr_we[c] && !i_core_disable[c] && (addr[c] == RW'(SREG_LOCK_ACQ))
                    && (data[c] < RW'(LOCKS));
      is_rel[c]   = i_sr_we[c] && !i_core_disable[c] && (addr[c] == RW'(SREG_LOCK_REL))
                    && (data[c] < RW'(LOCKS));
      bad_id[c]   = i_sr_we[c] && !i_core_disable[c] && (data[c] >= RW'(LOCKS))
                    && ((addr[c] == RW'(SREG_LOCK_ACQ)) || (addr[c] == RW'(SREG_LOCK_REL)));
      stat_clr[c] = i_sr_we[c] && (addr[c] == RW'(SREG_LOCK_STAT)) && data[c][STAT_ERR_BIT];
    end
  end

  // Disable, release and acquire bookkeeping before arbitration.
  always_comb begin
    owner_v_s = owner_v;
    pend_eff  = pend_v & ~i_core_disable;
    err_n     = err;
    acq_v     = '0;
    for (int l = 0; l < LOCKS; l++) begin
      for (int c = 0; c < CORES; c++) begin
        if (i_core_disable[c] && owner_v[l] && (owner_id[l] == CPW'(c))) owner_v_s[l] = 1'b0;
      end
    end
    for (int c = 0; c < CORES; c++) begin
      if (bad_id[c]) err_n[c] = 1'b1;
      if (is_rel[c]) begin
        if (owner_v[wid[c]] && (owner_id[wid[c]] == CPW'(c))) owner_v_s[wid[c]] = 1'b0;
        else if (pend_v[c] && (pend_id[c] == wid[c]))          pend_eff[c]       = 1'b0;
        else                                                   err_n[c]          = 1'b1;
      end
      if (is_acq[c] && !(owner_v[wid[c]] && (owner_id[wid[c]] == CPW'(c)))) begin
        acq_v[c]    = 1'b1;
        pend_eff[c] = 1'b0;
      end
      if (stat_clr[c]) err_n[c] = 1'b0;
    end
  end

  always_comb begin
    for (int l = 0; l < LOCKS; l++) begin
      req[l] = '0;
      for (int c = 0; c < CORES; c++) begin
        req[l][c] = (acq_v[c] && (wid[c] == IDW'(l))) || (pend_eff[c] && (pend_id[c] == IDW'(l)));
      end
    end
  end

  for (genvar l = 0; l < LOCKS; l++) begin : g_lock
    rr_arbiter #(.N(CORES)) u_arb (
      .req     (req[l]),
      .ptr     (rr_ptr),
      .gnt     (gnt[l]),
      .gnt_idx (gnt_idx[l]),
      .any     (gnt_any[l])
    );
  end

  // Grants on free locks; only the lowest contested lock moves the shared pointer.
  always_comb begin
    owner_v_n   = owner_v_s;
    owner_id_n  = owner_id;
    pend_v_n    = pend_eff;
    pend_id_n   = pend_id;
    grant_irq_n = '0;
    won         = '0;
    rr_ptr_n    = rr_ptr;
    rr_done     = 1'b0;
    for (int l = 0; l < LOCKS; l++) begin
      if (!owner_v_s[l] && gnt_any[l]) begin
        owner_v_n[l]  = 1'b1;
        owner_id_n[l] = gnt_idx[l];
        won          |= gnt[l];
        grant_irq_n  |= gnt[l] & ~acq_v;
        if (!rr_done && ($countones(req[l]) > 1)) begin
          rr_ptr_n = (gnt_idx[l] == CPW'(CORES - 1)) ? '0 : gnt_idx[l] + CPW'(1);
          rr_done  = 1'b1;
        end
      end
    end
    pend_v_n = pend_v_n & ~won;
    for (int c = 0; c < CORES; c++) begin
      if (acq_v[c] && !won[c]) begin
        pend_v_n[c]  = 1'b1;
        pend_id_n[c] = wid[c];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_v   <= '0;
      owner_id  <= '{default: '0};
      pend_v    <= '0;
      pend_id   <= '{default: '0};
      rr_ptr    <= '0;
      err       <= '0;
      grant_irq <= '0;
    end else begin
      owner_v   <= owner_v_n;
      owner_id  <= owner_id_n;
      pend_v    <= pend_v_n;
      pend_id   <= pend_id_n;
      rr_ptr    <= rr_ptr_n;
      err       <= err_n;
      grant_irq <= grant_irq_n;
    end
  end

  assign o_grant_irq = grant_irq;

  always_comb begin
    o_sr_data = '0;
    for (int c = 0; c < CORES; c++) begin
      if (addr[c] == RW'(SREG_LOCK_ACQ)) begin
        o_sr_data[c*RW + STAT_PEND_BIT] = pend_v[c];
        o_sr_data[c*RW +: IDW]          = pend_id[c];
      end else if (addr[c] == RW'(SREG_LOCK_STAT)) begin
        for (int l = 0; l < LOCKS; l++) begin
          o_sr_data[c*RW + l] = owner_v[l] && (owner_id[l] == CPW'(c));
        end
        o_sr_data[c*RW + STAT_ERR_BIT]  = err[c];
        o_sr_data[c*RW + STAT_PEND_BIT] = pend_v[c];
      end
    end
  end

endmodule

// File: tb/tb_intercore_lock_arbiter.sv
// Bench for intercore_lock_arbiter: directed vector table, async reset sequence, random vs model.
module tb_intercore_lock_arbiter;
  import intercore_lock_arbiter_pkg::*;

  localparam int CORES = 2;
  localparam int LOCKS = 8;
  localparam int RW    = 16;
  localparam logic [15:0] A_ACQ  = 16'h000C;
  localparam logic [15:0] A_REL  = 16'h000D;
  localparam logic [15:0] A_STAT = 16'h000E;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [CORES*RW-1:0] sr_addr, sr_data, rd_data;
  logic [CORES-1:0]    sr_we, dis, irq;
  int checks = 0;
  int errors = 0;

  intercore_lock_arbiter #(.CORES(CORES), .LOCKS(LOCKS), .RW(RW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sr_addr      (sr_addr),
    .i_sr_data      (sr_data),
    .i_sr_we        (sr_we),
    .o_sr_data      (rd_data),
    .i_core_disable (dis),
    .o_grant_irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] t_addr [CORES];
  logic [15:0] t_data [CORES];
  logic        t_we   [CORES];
  logic        t_dis  [CORES];

  task automatic apply();
    for (int c = 0; c < CORES; c++) begin
      sr_addr[c*RW +: RW] = t_addr[c];
      sr_data[c*RW +: RW] = t_data[c];
      sr_we[c]            = t_we[c];
      dis[c]              = t_dis[c];
    end
  endtask

  task automatic idle();
    for (int c = 0; c < CORES; c++) begin
      t_addr[c] = A_STAT; t_data[c] = '0; t_we[c] = 1'b0; t_dis[c] = 1'b0;
    end
    apply();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic op(input int c, input logic [15:0] a, input logic [15:0] d);
    idle();
    t_addr[c] = a; t_data[c] = d; t_we[c] = 1'b1;
    apply();
    @(posedge clk); #1;
    idle(); #1;
  endtask

  // Reference model: lock table, per-core pending slot, shared round-robin pointer.
  bit m_ov  [LOCKS];
  int m_oid [LOCKS];
  bit m_pv  [CORES];
  int m_pid [CORES];
  int m_rr;
  bit m_err [CORES];
  bit m_irq [CORES];

  function automatic void model_reset();
    for (int l = 0; l < LOCKS; l++) begin m_ov[l] = 0; m_oid[l] = 0; end
    for (int c = 0; c < CORES; c++) begin
      m_pv[c] = 0; m_pid[c] = 0; m_err[c] = 0; m_irq[c] = 0;
    end
    m_rr = 0;
  endfunction

  function automatic logic [15:0] model_read(input int c, input logic [15:0] a);
    logic [15:0] r;
    r = '0;
    if (a == A_ACQ) begin
      r[15]  = m_pv[c];
      r[2:0] = 3'(m_pid[c]);
    end else if (a == A_STAT) begin
      for (int l = 0; l < LOCKS; l++) if (m_ov[l] && m_oid[l] == c) r[l] = 1'b1;
      r[14] = m_err[c];
      r[15] = m_pv[c];
    end
    return r;
  endfunction

  function automatic void model_commit();
    bit nov [LOCKS]; int noid [LOCKS];
    bit npv [CORES]; int npid [CORES];
    bit nerr [CORES]; bit nirq [CORES];
    int acq [CORES];
    int nrr, id, n, w, c;
    bit rr_upd;
    nov = m_ov; noid = m_oid; npv = m_pv; npid = m_pid; nerr = m_err;
    nrr = m_rr; rr_upd = 0;
    for (int k = 0; k < CORES; k++) begin nirq[k] = 0; acq[k] = -1; end
    for (int k = 0; k < CORES; k++) begin
      if (t_dis[k]) begin
        for (int l = 0; l < LOCKS; l++) if (m_ov[l] && m_oid[l] == k) nov[l] = 0;
        npv[k] = 0;
      end
    end
    for (int k = 0; k < CORES; k++) begin
      id = int'(t_data[k]);
      if (t_we[k] && t_addr[k] == A_STAT && t_data[k][14]) nerr[k] = 0;
      if (t_we[k] && !t_dis[k] && (t_addr[k] == A_ACQ || t_addr[k] == A_REL)) begin
        if (id >= LOCKS) nerr[k] = 1;
        else if (t_addr[k] == A_REL) begin
          if (m_ov[id] && m_oid[id] == k) nov[id] = 0;
          else if (m_pv[k] && m_pid[k] == id) npv[k] = 0;
          else nerr[k] = 1;
        end else if (!(m_ov[id] && m_oid[id] == k)) begin
          acq[k] = id;
          npv[k] = 0;
        end
      end
    end
    for (int l = 0; l < LOCKS; l++) begin
      if (!nov[l]) begin
        n = 0; w = -1;
        for (int k = 0; k < CORES; k++) begin
          c = (m_rr + k) % CORES;
          if (acq[c] == l || (npv[c] && npid[c] == l)) begin
            n++;
            if (w < 0) w = c;
          end
        end
        if (n > 0) begin
          nov[l] = 1; noid[l] = w;
          nirq[w] = (acq[w] != l);
          npv[w] = 0;
          if (n > 1 && !rr_upd) begin nrr = (w + 1) % CORES; rr_upd = 1; end
        end
      end
    end
    for (int k = 0; k < CORES; k++) begin
      if (acq[k] >= 0 && !(nov[acq[k]] && noid[acq[k]] == k)) begin
        npv[k] = 1; npid[k] = acq[k];
      end
    end
    m_ov = nov; m_oid = noid; m_pv = npv; m_pid = npid; m_err = nerr; m_irq = nirq; m_rr = nrr;
  endfunction

  typedef struct {
    logic [1:0]  we;
    logic [15:0] a0, d0, a1, d1;
    logic [1:0]  dis;
    logic [15:0] s0, s1;
    logic [1:0]  irq;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] we, input logic [15:0] a0, input logic [15:0] d0,
                               input logic [15:0] a1, input logic [15:0] d1, input logic [1:0] dv,
                               input logic [15:0] s0, input logic [15:0] s1, input logic [1:0] ir);
    vec_t v;
    v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.dis = dv;
    v.s0 = s0; v.s1 = s1; v.irq = ir;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    tbl.push_back(mkv(2'b00, A_STAT, 16'd0, A_STAT, 16'd0, 2'b00, 16'h0000, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b01, A_ACQ,  16'd3, A_STAT, 16'd0, 2'b00, 16'h0008, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_ACQ,  16'd3, 2'b00, 16'h0008, 16'h8000, 2'b00));
    tbl.push_back(mkv(2'b00, A_STAT, 16'd0, A_STAT, 16'd0, 2'b00, 16'h0008, 16'h8000, 2'b00));
    tbl.push_back(mkv(2'b01, A_REL,  16'd3, A_STAT, 16'd0, 2'b00, 16'h0000, 16'h0008, 2'b10));
    tbl.push_back(mkv(2'b00, A_STAT, 16'd0, A_STAT, 16'd0, 2'b00, 16'h0000, 16'h0008, 2'b00));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_REL,  16'd3, 2'b00, 16'h0000, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b11, A_ACQ,  16'd5, A_ACQ,  16'd5, 2'b00, 16'h0020, 16'h8000, 2'b00));
    tbl.push_back(mkv(2'b01, A_REL,  16'd5, A_STAT, 16'd0, 2'b00, 16'h0000, 16'h0020, 2'b10));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_REL,  16'd5, 2'b00, 16'h0000, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b11, A_ACQ,  16'd5, A_ACQ,  16'd5, 2'b00, 16'h8000, 16'h0020, 2'b00));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_REL,  16'd5, 2'b00, 16'h0020, 16'h0000, 2'b01));
    tbl.push_back(mkv(2'b01, A_REL,  16'd5, A_STAT, 16'd0, 2'b00, 16'h0000, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_REL,  16'd2, 2'b00, 16'h0000, 16'h4000, 2'b00));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_STAT, 16'h4000, 2'b00, 16'h0000, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b11, A_ACQ,  16'd6, A_ACQ,  16'd1, 2'b00, 16'h0040, 16'h0002, 2'b00));
    tbl.push_back(mkv(2'b10, A_STAT, 16'd0, A_ACQ,  16'd4, 2'b00, 16'h0040, 16'h0012, 2'b00));
    tbl.push_back(mkv(2'b11, A_ACQ,  16'd4, A_ACQ,  16'd6, 2'b00, 16'h8040, 16'h8012, 2'b00));
    tbl.push_back(mkv(2'b00, A_STAT, 16'd0, A_STAT, 16'd0, 2'b10, 16'h0050, 16'h0000, 2'b01));
    tbl.push_back(mkv(2'b00, A_STAT, 16'd0, A_STAT, 16'd0, 2'b00, 16'h0050, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b01, A_ACQ,  16'd9, A_STAT, 16'd0, 2'b00, 16'h4050, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b11, A_REL,  16'd6, A_ACQ,  16'd6, 2'b00, 16'h4010, 16'h0040, 2'b00));
    tbl.push_back(mkv(2'b11, A_REL,  16'd4, A_REL,  16'd6, 2'b00, 16'h4000, 16'h0000, 2'b00));
    tbl.push_back(mkv(2'b01, A_STAT, 16'h4000, A_STAT, 16'd0, 2'b00, 16'h0000, 16'h0000, 2'b00));

    idle();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      t_we[0] = tbl[i].we[0];  t_addr[0] = tbl[i].a0; t_data[0] = tbl[i].d0; t_dis[0] = tbl[i].dis[0];
      t_we[1] = tbl[i].we[1];  t_addr[1] = tbl[i].a1; t_data[1] = tbl[i].d1; t_dis[1] = tbl[i].dis[1];
      apply();
      @(posedge clk); #1;
      idle(); #1;
      chk($sformatf("vec%0d_stat0", i), {16'h0, rd_data[15:0]},  {16'h0, tbl[i].s0});
      chk($sformatf("vec%0d_stat1", i), {16'h0, rd_data[31:16]}, {16'h0, tbl[i].s1});
      chk($sformatf("vec%0d_irq", i),   {30'h0, irq},            {30'h0, tbl[i].irq});
      if (i == 17) begin
        t_addr[0] = A_ACQ; t_addr[1] = A_ACQ; apply(); #1;
        chk("acq_read0", {16'h0, rd_data[15:0]},  32'h8004);
        chk("acq_read1", {16'h0, rd_data[31:16]}, 32'h8006);
        idle();
      end
    end

    // Async reset while a lock is held, a waiter was just granted and an acquire is in flight.
    op(0, A_ACQ, 16'd7);
    op(0, A_ACQ, 16'd2);
    op(1, A_ACQ, 16'd2);
    chk("pre_rst_pend", {16'h0, rd_data[31:16]}, 32'h8000);
    op(0, A_REL, 16'd2);
    chk("pre_rst_irq",   {30'h0, irq},           32'h2);
    chk("pre_rst_stat1", {16'h0, rd_data[31:16]}, 32'h0004);
    t_we[1] = 1'b1; t_addr[1] = A_ACQ; t_data[1] = 16'd7; apply();
    #2 rst_n = 1'b0;
    #1 idle(); #1;
    chk("rst_stat0", {16'h0, rd_data[15:0]},  32'h0);
    chk("rst_stat1", {16'h0, rd_data[31:16]}, 32'h0);
    chk("rst_irq",   {30'h0, irq},            32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stat0", {16'h0, rd_data[15:0]}, 32'h0);

    // Randomized traffic against the reference model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CORES; c++) begin
        int r;
        t_we[c] = ($urandom_range(0, 9) < 6);
        r = int'($urandom_range(0, 99));
        if (r < 35)      t_addr[c] = A_ACQ;
        else if (r < 65) t_addr[c] = A_REL;
        else if (r < 90) t_addr[c] = A_STAT;
        else             t_addr[c] = (r % 2 == 0) ? 16'h0000 : 16'h000F;
        if (t_addr[c] == A_ACQ || t_addr[c] == A_REL)
          t_data[c] = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 12));
        else
          t_data[c] = 16'($urandom);
        t_dis[c] = ($urandom_range(0, 99) < 3);
      end
      apply(); #1;
      for (int c = 0; c < CORES; c++) begin
        chk($sformatf("rnd%0d_rd%0d", n, c), {16'h0, rd_data[c*RW +: RW]}, {16'h0, model_read(c, t_addr[c])});
        chk($sformatf("rnd%0d_irq%0d", n, c), {31'h0, irq[c]}, {31'h0, m_irq[c]});
      end
      model_commit();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
